// File: rtl/seq_multiplier.sv
// seq_multiplier
//   Unsigned shift-add multiplier. One operand pair is accepted per
//   operation; the product appears WIDTH clock edges after the accepting
//   edge. The latency is the same for every operand value.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      begin a multiply (only sampled while idle)
//   A_in       unsigned multiplicand, captured on the accepting edge
//   B_in       unsigned multiplier, captured on the accepting edge
//   P          2*WIDTH-bit product register, held until the next accepted start
//   busy       high from the accepting edge until done rises
//   done       one-cycle completion pulse
//   zero_flag  high when either captured operand was zero
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A_in,
    input  logic [WIDTH-1:0]   B_in,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done,
    output logic               zero_flag
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 zero_q, zero_d;

    // Partial sum for the current step. The accumulator's top bit is always
    // zero at the start of a step, so WIDTH+1 bits hold the sum with its carry.
    logic [WIDTH:0]       sum;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        zero_d   = zero_q;
        sum      = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = A_in;
                    mplier_d = B_in;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(WIDTH);
                    busy_d   = 1'b1;
                    zero_d   = (A_in == '0) || (B_in == '0);
                    state_d  = S_CALC;
                end
            end

            S_CALC: begin
                // Shift {sum, multiplier} right by one: the sum's LSB becomes
                // a finished product bit entering the multiplier register.
                acc_d    = {1'b0, sum[WIDTH:1]};
                mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last step: the shifted pair is the full product.
                    p_d     = {sum, mplier_q[WIDTH-1:1]};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
        end
    end

    assign P         = p_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier at WIDTH=4. Stimulus pushes the expected
// product, zero flag and accept cycle into a queue; a monitor on the falling
// edge pops an entry on every done pulse and checks outputs in between.
module tb_seq_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_in = '0;
    logic [W-1:0]   b_in = '0;
    logic [2*W-1:0] p;
    logic           busy;
    logic           done;
    logic           zf;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A_in      (a_in),
        .B_in      (b_in),
        .P         (p),
        .busy      (busy),
        .done      (done),
        .zero_flag (zf)
    );

    typedef struct {
        int unsigned p;
        bit          z;
        int unsigned acc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    int unsigned exp_p = 0;
    bit          exp_z = 1'b0;
    bit          prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation;
    // between pulses P and zero_flag must hold their last values.
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                check("done_width", prev_done, 0);
                check("busy_with_done", busy, 0);
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: done high with no operation outstanding, P=%0d", p);
                end else begin
                    mon_e = sb.pop_front();
                    check("product", p, mon_e.p);
                    check("zero_flag", zf, mon_e.z);
                    check("latency", cyc - mon_e.acc, W);
                    exp_p = mon_e.p;
                    exp_z = mon_e.z;
                end
            end else begin
                check("p_hold", p, exp_p);
                check("zf_hold", zf, exp_z);
            end
            prev_done = done;
        end
    end

    // Called at posedge+2; returns once the DUT is idle (neither busy nor done).
    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy && !done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: DUT not idle after 60 cycles, busy=%0d done=%0d", busy, done);
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int unsigned acc);
        int unsigned ua = a;
        int unsigned ub = b;
        bit          z  = (a == 0) || (b == 0);
        wait_idle();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        acc   = cyc;
        sb.push_back('{ua * ub, z, cyc});
        exp_z = z;
        check("busy_after_accept", busy, 1);
        // Operand changes after the accepting edge must be ignored.
        a_in = W'($urandom);
        b_in = W'($urandom);
    endtask

    initial begin
        int unsigned c1, c2, c;

        // Reset
        repeat (3) @(posedge clk);
        #2;
        check("rst_p", p, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_zf", zf, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Max operands (accepted on first edge after reset), then zero operand
        do_op(4'd15, 4'd15, c);
        do_op(4'd0, 4'd9, c);

        // Typical values, back-to-back
        do_op(4'd7, 4'd3, c1);
        do_op(4'd12, 4'd5, c2);
        check("b2b_spacing", c2 - c1, W + 2);

        // Start while busy is ignored
        do_op(4'd6, 4'd6, c);
        start = 1'b1;
        a_in  = 4'd1;
        b_in  = 4'd1;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        start = 1'b0;

        // Reset on the second CALC edge aborts the operation
        do_op(4'd9, 4'd9, c);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst   = 1'b0;
        sb.delete();
        exp_p = 0;
        exp_z = 1'b0;
        check("abort_p", p, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        do_op(4'd2, 4'd3, c);

        // Randomized operands with random idle gaps
        for (int i = 0; i < 40; i++) begin
            do_op(W'($urandom), W'($urandom), c);
            repeat ($urandom_range(0, 8)) begin
                @(posedge clk);
                #2;
            end
        end

        // Exhaustive, back-to-back
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_op(W'(a), W'(b), c);
            end
        end

        // Drain
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d operations without a done pulse", sb.size());
        end
        repeat (2) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL provide parameter: WIDTH, default 4, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: A_in  input  WIDTH  unsigned multiplicand; captured on the accepting edge.
REQ-006 SHALL have port: B_in  input  WIDTH  unsigned multiplier; captured on the accepting edge.
REQ-007 SHALL have port: P  output  2*WIDTH  product register; valid while done=1; held until the next accepted start.
REQ-008 SHALL have port: busy  output  1  high from the accepting edge until done is asserted.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: zero_flag  output  1  registered; high when either captured operand equals 0.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 SHALL, in IDLE with start=1, perform the following on one edge:
- capture A_in into the multiplicand register and B_in into the multiplier shift register;
- clear the (WIDTH+1)-bit accumulator;
- load the iteration counter with WIDTH;
- set busy=1;
- set zero_flag to (A_in==0 || B_in==0);
- go to CALC.
REQ-013 SHALL, on each CALC edge, perform one shift-add step:
- if the multiplier LSB is 1, add the multiplicand to the accumulator with carry retained (WIDTH+1 bits);
- shift {carry, accumulator, multiplier} right by one bit;
- decrement the counter.
REQ-014 SHALL leave CALC after exactly WIDTH iterations. On the last CALC edge it SHALL:
- load P with {accumulator, multiplier} (the full 2*WIDTH-bit product);
- set done=1 and busy=0;
- go to DONE.
REQ-015 SHALL assert done for exactly one cycle, then return to IDLE with done=0 on the next edge.
REQ-016 SHALL have fixed latency: done is high in the cycle following the WIDTH-th edge after the accepting edge (4 CALC edges for WIDTH=4), independent of operand values, including zero operands.
REQ-017 SHALL ignore start while in CALC or DONE: no restart, no capture, no effect on P.
REQ-018 SHALL accept a start asserted in the first IDLE cycle after DONE, so back-to-back operations are spaced WIDTH+2 cycles apart.
REQ-019 SHALL give the product in P the exact unsigned value A*B without overflow; maximum is (2^WIDTH-1)^2, e.g. 225 for WIDTH=4.
REQ-020 SHALL hold P and zero_flag from the end of one operation until the next accepted start.
REQ-021 SHALL ignore changes on A_in and B_in after the accepting edge.
REQ-022 SHALL generate all outputs from registers, with no combinational path from inputs to outputs.

Reset
REQ-023 SHALL, on any rising edge with rst=1, set:
- state=IDLE;
- P=0, busy=0, done=0, zero_flag=0;
- accumulator, multiplicand, multiplier and counter registers to 0.
REQ-024 SHALL give rst priority over start and over any in-progress CALC step.
REQ-025 SHALL, when rst is asserted mid-operation, abort the operation with no done pulse and no update of P.
REQ-026 SHALL accept a start on the first edge after rst deasserts.

Verification
REQ-027 SHALL be covered by a bench at WIDTH=4 running these directed scenarios:
- Max operands: A=15, B=15, start one cycle -> done high exactly 4 edges after the accept edge, P=8'hE1 (225), zero_flag=0, busy low with done.
- Zero operand: A=0, B=9 -> P=0, zero_flag=1, done still at 4-edge latency.
- Typical values: A=7, B=3 -> P=21. Then start in the first IDLE cycle after DONE with A=12, B=5 -> P=60, P holds 21 until the second result loads.
- Start while busy: A=6, B=6 accepted; during CALC assert start with A=1, B=1 -> ignored, P=36, single done pulse.
- Reset mid-operation: accept A=9, B=9, assert rst on the 2nd CALC edge -> no done, P=0, busy=0; next start with A=2, B=3 -> P=6.
- Exhaustive check: all 256 operand pairs issued back-to-back -> each P equals A*B and each done is exactly one cycle wide.
